// File: rtl/spi_host_master_if.sv
// Signal bundle between spi_host_master and its user: start/status, tx/rx
// byte streams and the shared SPI bus. The master modport is the host side.
interface spi_host_master_if;
  logic       start_i;
  logic [1:0] target_i;
  logic [7:0] len_i;
  logic       busy_o;
  logic       err_o;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       done_o;
  logic       sclk_o;
  logic       di_o;
  logic       do_i;
  logic       ncs1_o;
  logic       ncs2_o;

  modport master (
    input  start_i, target_i, len_i, tx_data_i, tx_valid_i, do_i,
    output busy_o, err_o, tx_ready_o, rx_data_o, rx_valid_o, done_o,
           sclk_o, di_o, ncs1_o, ncs2_o
  );

  modport slave (
    output start_i, target_i, len_i, tx_data_i, tx_valid_i, do_i,
    input  busy_o, err_o, tx_ready_o, rx_data_o, rx_valid_o, done_o,
           sclk_o, di_o, ncs1_o, ncs2_o
  );
endinterface

// File: rtl/spi_host_master.sv
// SPI mode-0 host with 2-line encoded select ({ncs2,ncs1} = device index, 11 idle).
// Define SPI_LSB_FIRST_EN to shift LSB first; default is MSB first.
module spi_host_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 8
) (
  input logic               clk_i,
  input logic               reset_i,
  spi_host_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETUP, S_SHIFT, S_HOLD, S_GAP
  } state_e;

  localparam int unsigned      CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);

`ifdef SPI_LSB_FIRST_EN
  function automatic logic head_bit(input logic [7:0] b);
    return b[0];
  endfunction
  function automatic logic [7:0] drop_head(input logic [7:0] b);
    return {1'b0, b[7:1]};
  endfunction
  function automatic logic [7:0] push_bit(input logic [7:0] b, input logic s);
    return {s, b[7:1]};
  endfunction
`else
  function automatic logic head_bit(input logic [7:0] b);
    return b[7];
  endfunction
  function automatic logic [7:0] drop_head(input logic [7:0] b);
    return {b[6:0], 1'b0};
  endfunction
  function automatic logic [7:0] push_bit(input logic [7:0] b, input logic s);
    return {b[6:0], s};
  endfunction
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       bytes_left_q, bytes_left_d;
  logic [1:0]       target_q, target_d;
  logic             first_q, first_d;
  logic [7:0]       tx_sh_q, tx_sh_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             sclk_q, sclk_d;
  logic             di_q, di_d;
  logic [1:0]       ncs_q, ncs_d;

  logic start_legal;
  logic div_last;
  logic gap_last;

  assign start_legal = (bus.target_i != 2'd3) && (bus.len_i != 8'd0);
  assign div_last    = (cnt_q == DIV_LAST);
  assign gap_last    = (cnt_q == GAP_LAST);

  // NOTE: every signal gets its default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    bytes_left_d = bytes_left_q;
    target_d     = target_q;
    first_d      = first_q;
    tx_sh_d      = tx_sh_q;
    rx_sh_d      = rx_sh_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    sclk_d       = sclk_q;
    di_d         = di_q;
    ncs_d        = ncs_q;

    unique case (state_q)
      S_IDLE: begin
        // The cycle in which done is high still counts as the tail of the
        // previous transaction, so a start there is dropped silently.
        if (bus.start_i && !done_q) begin
          if (start_legal) begin
            target_d     = bus.target_i;
            bytes_left_d = bus.len_i;
            first_d      = 1'b1;
            state_d      = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_LOAD: begin
        if (bus.tx_valid_i) begin
          tx_sh_d = drop_head(bus.tx_data_i);
          di_d    = head_bit(bus.tx_data_i);
          cnt_d   = '0;
          bit_d   = 3'd0;
          if (first_q) begin
            ncs_d   = target_q;
            first_d = 1'b0;
            state_d = S_SETUP;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end

      S_SETUP: begin
        if (div_last) begin
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_SHIFT: begin
        if (!div_last) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d  = '0;
          sclk_d = !sclk_q;
          if (!sclk_q) begin
            rx_sh_d = push_bit(rx_sh_q, bus.do_i);
          end else begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              rx_data_d    = rx_sh_q;
              rx_valid_d   = 1'b1;
              bytes_left_d = bytes_left_q - 8'd1;
              state_d      = (bytes_left_q == 8'd1) ? S_HOLD : S_LOAD;
            end else begin
              di_d    = head_bit(tx_sh_q);
              tx_sh_d = drop_head(tx_sh_q);
            end
          end
        end
      end

      S_HOLD: begin
        if (div_last) begin
          cnt_d   = '0;
          ncs_d   = 2'b11;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_GAP: begin
        if (gap_last) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= 3'd0;
      bytes_left_q <= 8'd0;
      target_q     <= 2'd0;
      first_q      <= 1'b0;
      tx_sh_q      <= 8'd0;
      rx_sh_q      <= 8'd0;
      rx_data_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      sclk_q       <= 1'b0;
      di_q         <= 1'b0;
      ncs_q        <= 2'b11;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      bytes_left_q <= bytes_left_d;
      target_q     <= target_d;
      first_q      <= first_d;
      tx_sh_q      <= tx_sh_d;
      rx_sh_q      <= rx_sh_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      done_q       <= done_d;
      err_q        <= err_d;
      sclk_q       <= sclk_d;
      di_q         <= di_d;
      ncs_q        <= ncs_d;
    end
  end

  assign bus.busy_o     = (state_q != S_IDLE);
  assign bus.tx_ready_o = (state_q == S_LOAD);
  assign bus.err_o      = err_q;
  assign bus.rx_data_o  = rx_data_q;
  assign bus.rx_valid_o = rx_valid_q;
  assign bus.done_o     = done_q;
  assign bus.sclk_o     = sclk_q;
  assign bus.di_o       = di_q;
  assign bus.ncs1_o     = ncs_q[0];
  assign bus.ncs2_o     = ncs_q[1];

endmodule

// File: tb/tb_spi_host_master.sv
// Directed bench for spi_host_master: a bus monitor plays the SPI slave and
// scoreboards MOSI bytes, rx bytes and sclk/select timing against queues.
module tb_spi_host_master;

  localparam int CLK_DIV = 4;
  localparam int CS_GAP  = 8;
  localparam int BOUND   = 2000;
  localparam logic [16:0] RESET_VEC = {7'b0000000, 2'b11, 8'h00};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_host_master_if sif ();

  spi_host_master #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus    (sif)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  logic [7:0] slave_q[$];
  logic [1:0] exp_sel = 2'b11;

  int done_cnt = 0, rx_cnt = 0, desel_cnt = 0;
  int gap_min = 1000, gap_max = 0;
  int rise_in_byte = 0, byte_cnt = 0, low_len = 0, high_len = 0, gap_len = 0;
  logic [2:0] s_bit;
  logic [7:0] cap, s_byte;
  logic       sclk_prev;
  logic [1:0] sel_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  function automatic logic [16:0] pack_out();
    return {sif.busy_o, sif.err_o, sif.tx_ready_o, sif.rx_valid_o, sif.done_o,
            sif.sclk_o, sif.di_o, sif.ncs2_o, sif.ncs1_o, sif.rx_data_o};
  endfunction

  function automatic logic [7:0] next_slave_byte();
    return (slave_q.size() > 0) ? slave_q.pop_front() : 8'hFF;
  endfunction

  // Slave model and scoreboard, sampling on the falling clk edge.
  always @(negedge clk) begin : monitor
    logic [1:0] sel;
    sel = {sif.ncs2_o, sif.ncs1_o};
    if (reset) begin
      rise_in_byte = 0; byte_cnt = 0; low_len = 0; high_len = 0; gap_len = 0;
      s_bit = 3'd0; cap = 8'h00; s_byte = 8'hFF;
      sclk_prev = 1'b0; sel_prev = 2'b11; sif.do_i = 1'b1;
    end else begin
      if (sif.done_o) begin
        check("cs_gap_len", gap_len, CS_GAP);
        done_cnt++;
      end
      gap_len = (sif.busy_o && sel == 2'b11) ? gap_len + 1 : 0;

      if (sif.rx_valid_o) begin
        rx_cnt++;
        check("rx_expected", 32'(exp_rx.size() > 0), 1);
        if (exp_rx.size() > 0) check("rx_data", sif.rx_data_o, exp_rx.pop_front());
      end

      if (sel_prev == 2'b11 && sel != 2'b11) begin
        byte_cnt = 0; rise_in_byte = 0; s_bit = 3'd0;
        s_byte = next_slave_byte();
      end
      if (sel_prev != 2'b11 && sel == 2'b11) begin
        desel_cnt++;
        check("hold_low_len", low_len, CLK_DIV);
      end

      if (sif.sclk_o && !sclk_prev) begin
        if (rise_in_byte != 0) check("sclk_low_len", low_len, CLK_DIV);
        else if (byte_cnt != 0) begin
          if (low_len < gap_min) gap_min = low_len;
          if (low_len > gap_max) gap_max = low_len;
        end
        check("sel_during_shift", sel, exp_sel);
`ifdef SPI_LSB_FIRST_EN
        cap = {sif.di_o, cap[7:1]};
`else
        cap = {cap[6:0], sif.di_o};
`endif
        rise_in_byte++;
        if (rise_in_byte == 8) begin
          check("tx_expected", 32'(exp_tx.size() > 0), 1);
          if (exp_tx.size() > 0) check("mosi_byte", cap, exp_tx.pop_front());
          rise_in_byte = 0;
          byte_cnt++;
        end
        high_len = 1;
      end else if (sif.sclk_o) begin
        high_len++;
      end

      if (!sif.sclk_o && sclk_prev) begin
        check("sclk_high_len", high_len, CLK_DIV);
        low_len = 1;
        if (s_bit == 3'd7) s_byte = next_slave_byte();
        s_bit = s_bit + 3'd1;
      end else if (!sif.sclk_o) begin
        low_len++;
      end

`ifdef SPI_LSB_FIRST_EN
      sif.do_i = (sel == 2'b11) ? 1'b1 : s_byte[s_bit];
`else
      sif.do_i = (sel == 2'b11) ? 1'b1 : s_byte[~s_bit];
`endif
      sclk_prev = sif.sclk_o;
      sel_prev  = sel;
    end
  end

  task automatic start_xfer(input logic [1:0] t, input logic [7:0] l);
    sif.target_i = t;
    sif.len_i    = l;
    sif.start_i  = 1'b1;
    @(negedge clk);
    sif.start_i  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    sif.tx_data_i  = b;
    sif.tx_valid_i = 1'b1;
    exp_tx.push_back(b);
    while (!sif.tx_ready_o && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("tx_ready_timeout", 32'(n < BOUND), 1);
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!sif.done_o && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 32'(n < BOUND), 1);
  endtask

  task automatic slave_and_expect(input logic [7:0] b);
    slave_q.push_back(b);
    exp_rx.push_back(b);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0, r0, s0, n, bad;
    reset          = 1'b1;
    sif.start_i    = 1'b0;
    sif.target_i   = 2'd0;
    sif.len_i      = 8'd0;
    sif.tx_data_i  = 8'h00;
    sif.tx_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", pack_out(), RESET_VEC);
    reset = 1'b0;
    @(negedge clk);
    check("idle_outputs", pack_out(), RESET_VEC);

    // T1: single byte to device 1
    exp_sel = 2'b01;
    slave_and_expect(8'h3C);
    d0 = done_cnt; r0 = rx_cnt; s0 = desel_cnt;
    start_xfer(2'd1, 8'd1);
    check("t1_busy_next_cycle", sif.busy_o, 1);
    check("t1_tx_ready", sif.tx_ready_o, 1);
    send_byte(8'hA5);
    sif.tx_valid_i = 1'b0;
    wait_done();
    check("t1_busy_at_done", sif.busy_o, 0);
    @(negedge clk);
    check("t1_done_once", done_cnt - d0, 1);
    check("t1_rx_count", rx_cnt - r0, 1);
    check("t1_sel_idle", {sif.ncs2_o, sif.ncs1_o}, 2'b11);
    check("t1_rx_data_holds", sif.rx_data_o, 8'h3C);

    // T2: three bytes to device 2 with tx_valid held high
    exp_sel = 2'b10;
    slave_and_expect(8'h81);
    slave_and_expect(8'h42);
    slave_and_expect(8'hE7);
    d0 = done_cnt; r0 = rx_cnt; s0 = desel_cnt;
    gap_min = 1000; gap_max = 0;
    start_xfer(2'd2, 8'd3);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    sif.tx_valid_i = 1'b0;
    wait_done();
    @(negedge clk);
    check("t2_rx_count", rx_cnt - r0, 3);
    check("t2_desel_once", desel_cnt - s0, 1);
    check("t2_gap_min", gap_min, 1 + CLK_DIV);
    check("t2_gap_max", gap_max, 1 + CLK_DIV);
    check("t2_done_once", done_cnt - d0, 1);

    // T3: underrun between the two bytes to device 0
    exp_sel = 2'b00;
    slave_and_expect(8'h55);
    slave_and_expect(8'hAA);
    d0 = done_cnt; r0 = rx_cnt;
    start_xfer(2'd0, 8'd2);
    send_byte(8'h3C);
    sif.tx_valid_i = 1'b0;
    n = 0;
    while (!sif.tx_ready_o && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("t3_reach_load", 32'(n < BOUND), 1);
    bad = 0;
    repeat (50) begin
      if (sif.sclk_o !== 1'b0 || {sif.ncs2_o, sif.ncs1_o} !== 2'b00 || sif.busy_o !== 1'b1) bad++;
      @(negedge clk);
    end
    check("t3_stall_bus", bad, 0);
    send_byte(8'hC3);
    sif.tx_valid_i = 1'b0;
    wait_done();
    @(negedge clk);
    check("t3_rx_count", rx_cnt - r0, 2);
    check("t3_done_once", done_cnt - d0, 1);

    // T4: illegal starts, starts while busy, start in the done cycle
    d0 = done_cnt;
    start_xfer(2'd3, 8'd1);
    check("t4_err_target3", sif.err_o, 1);
    check("t4_busy_target3", sif.busy_o, 0);
    @(negedge clk);
    check("t4_err_one_cycle", sif.err_o, 0);
    start_xfer(2'd0, 8'd0);
    check("t4_err_len0", sif.err_o, 1);
    check("t4_busy_len0", sif.busy_o, 0);
    @(negedge clk);
    check("t4_bus_idle", {sif.busy_o, sif.sclk_o, sif.ncs2_o, sif.ncs1_o}, 4'b0011);
    exp_sel = 2'b10;
    slave_and_expect(8'hC3);
    r0 = rx_cnt;
    start_xfer(2'd2, 8'd1);
    send_byte(8'h5A);
    sif.tx_valid_i = 1'b0;
    repeat (10) @(negedge clk);
    start_xfer(2'd3, 8'd0);
    check("t4_no_err_while_busy", sif.err_o, 0);
    start_xfer(2'd0, 8'd5);
    check("t4_busy_kept", sif.busy_o, 1);
    wait_done();
    sif.target_i = 2'd1;
    sif.len_i    = 8'd1;
    sif.start_i  = 1'b1;
    @(negedge clk);
    sif.start_i  = 1'b0;
    check("t4_start_at_done_ignored", sif.busy_o, 0);
    check("t4_done_once", done_cnt - d0, 1);
    check("t4_rx_count", rx_cnt - r0, 1);

    // T5: reset in the middle of bit 4, then a clean transaction
    exp_sel = 2'b01;
    for (int i = 0; i < 4; i++) slave_and_expect(8'(8'h10 + i));
    d0 = done_cnt;
    start_xfer(2'd1, 8'd4);
    send_byte(8'h96);
    sif.tx_valid_i = 1'b0;
    n = 0;
    while (rise_in_byte < 4 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("t5_reach_bit4", 32'(n < BOUND), 1);
    reset = 1'b1;
    @(negedge clk);
    check("t5_reset_outputs", pack_out(), RESET_VEC);
    exp_rx.delete();
    exp_tx.delete();
    slave_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (CS_GAP + 4) @(negedge clk);
    check("t5_no_done_after_reset", done_cnt - d0, 0);
    exp_sel = 2'b10;
    slave_and_expect(8'h96);
    slave_and_expect(8'h69);
    r0 = rx_cnt;
    start_xfer(2'd2, 8'd2);
    send_byte(8'hF0);
    send_byte(8'h0F);
    sif.tx_valid_i = 1'b0;
    wait_done();
    @(negedge clk);
    check("t5_fresh_rx_count", rx_cnt - r0, 2);
    check("t5_fresh_done_once", done_cnt - d0, 1);

    check("end_rx_queue_empty", exp_rx.size(), 0);
    check("end_tx_queue_empty", exp_tx.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
